// File: rtl/ram_to_weight_fifo_pipe.sv
// Weight tile fetcher: walks a Tn x Tm x K x K tile of weight words in RAM
// and streams them, zero padded outside N/M, into a downstream FIFO.
module ram_to_weight_fifo_pipe #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int N      = 32,
  parameter int M      = 32,
  parameter int K      = 3,
  parameter int Tn     = 8,
  parameter int Tm     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] tile_base_n,
  input  logic [AW-1:0] tile_base_m,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] data_from_ram,
  output logic          fifo_push,
  output logic [DW-1:0] data_to_fifo,
  input  logic          fifo_almost_full
);

  localparam int CW = $clog2(RD_LAT + 1) + 1;
  localparam int KW = $clog2(K + 1);
  localparam int NW = $clog2(Tn + 1);
  localparam int MW = $clog2(Tm + 1);

  localparam logic [AW-1:0] KA  = AW'(K);
  localparam logic [AW-1:0] KK  = AW'(K * K);
  localparam logic [AW-1:0] MKK = AW'(M * K * K);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0]     base_n, base_m;
  logic [KW-1:0]     j, i;
  logic [MW-1:0]     tm;
  logic [NW-1:0]     tn;
  logic [CW-1:0]     inflight;
  logic [RD_LAT-1:0] pv, pin;

  logic          issue, last, inr, accept;
  logic [AW-1:0] ch_n, ch_m, addr;
  logic [AW:0]   sum_n, sum_m;

  assign issue = (state == ISSUE) && !fifo_almost_full;
  assign last  = (j == KW'(K - 1)) && (i == KW'(K - 1)) &&
                 (tm == MW'(Tm - 1)) && (tn == NW'(Tn - 1));

  assign ch_n = base_n + AW'(tn);
  assign ch_m = base_m + AW'(tm);
  assign addr = ch_n * MKK + ch_m * KK + AW'(i) * KA + AW'(j);

  // one extra bit so a base near 2^AW cannot wrap back into range
  assign sum_n = {1'b0, base_n} + (AW+1)'(tn);
  assign sum_m = {1'b0, base_m} + (AW+1)'(tm);
  assign inr   = (sum_n < (AW+1)'(N)) && (sum_m < (AW+1)'(M));

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (issue && last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0) begin
          done = 1'b1;
          if (start) begin
            accept   = 1'b1;
            state_nx = ISSUE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_n <= '0;
      base_m <= '0;
      j      <= '0;
      i      <= '0;
      tm     <= '0;
      tn     <= '0;
    end else if (accept) begin
      base_n <= tile_base_n;
      base_m <= tile_base_m;
      j      <= '0;
      i      <= '0;
      tm     <= '0;
      tn     <= '0;
    end else if (issue) begin
      if (j == KW'(K - 1)) begin
        j <= '0;
        if (i == KW'(K - 1)) begin
          i <= '0;
          if (tm == MW'(Tm - 1)) begin
            tm <= '0;
            tn <= tn + NW'(1);
          end else begin
            tm <= tm + MW'(1);
          end
        end else begin
          i <= i + KW'(1);
        end
      end else begin
        j <= j + KW'(1);
      end
    end
  end

  // valid/in-range bits ride alongside the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv       <= '0;
      pin      <= '0;
      inflight <= '0;
    end else begin
      pv       <= RD_LAT'({pv, issue});
      pin      <= RD_LAT'({pin, issue & inr});
      inflight <= inflight + CW'(issue) - CW'(fifo_push);
    end
  end

  assign busy         = (state != IDLE);
  assign ram_rd       = issue && inr;
  assign ram_addr     = (state == ISSUE) ? addr : '0;
  assign fifo_push    = pv[RD_LAT-1];
  assign data_to_fifo = (fifo_push && pin[RD_LAT-1]) ? data_from_ram : '0;

endmodule

// File: tb/tb_ram_to_weight_fifo_pipe.sv
// Bench for ram_to_weight_fifo_pipe: two instances (RD_LAT 2 and 4) share
// stimulus; each has a RAM model, a tile reference model and a scoreboard.
module tb_ram_to_weight_fifo_pipe;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int K  = 3;
  localparam int TN = 2;
  localparam int TM = 2;
  localparam int LIM = 800;

  typedef struct {
    int          c;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    bit          inr;
  } el_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        af = 1'b0;
  logic [31:0] bn = '0;
  logic [31:0] bm = '0;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : 4;

    logic        busy, done, ram_rd, push;
    logic [31:0] ram_addr, dfr, dtf, junk;
    logic [31:0] da [L];
    logic        dr [L];

    el_t         elems[$];
    exp_t        expq[$];
    logic [31:0] rdq[$];
    int          left = 0;
    int          last = 0;
    bit          active = 1'b0;

    ram_to_weight_fifo_pipe #(
      .AW(32), .DW(32), .N(N), .M(M), .K(K),
      .Tn(TN), .Tm(TM), .RD_LAT(L)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .busy(busy),
      .done(done),
      .tile_base_n(bn),
      .tile_base_m(bm),
      .ram_rd(ram_rd),
      .ram_addr(ram_addr),
      .data_from_ram(dfr),
      .fifo_push(push),
      .data_to_fifo(dtf),
      .fifo_almost_full(af)
    );

    // RAM with L-cycle latency; junk on the bus when nothing was read
    always @(posedge clk) begin
      for (int s = L - 1; s > 0; s--) begin
        da[s] <= da[s-1];
        dr[s] <= dr[s-1];
      end
      da[0] <= ram_addr;
      dr[0] <= ram_rd;
      junk  <= $urandom;
    end
    assign dfr = dr[L-1] ? hash(da[L-1]) : junk;

    always @(negedge clk) begin
      bit          dm;
      el_t         e;
      exp_t        x;
      logic [31:0] a;
      if (!rst_n) begin
        elems.delete();
        expq.delete();
        rdq.delete();
        left   = 0;
        last   = 0;
        active = 1'b0;
        chk(!push && !ram_rd && !done && !busy,
            $sformatf("L%0d.rst_ctl", L),
            {push, ram_rd, done, busy}, 0);
        chk(ram_addr == 0 && dtf == 0,
            $sformatf("L%0d.rst_data", L), ram_addr | dtf, 0);
      end else begin
        chk(busy == active, $sformatf("L%0d.busy", L), busy, active);
        dm = active && left == 0 && cyc == last + L + 1;
        if (dm || done)
          chk(done == dm, $sformatf("L%0d.done", L), done, dm);
        // model: one element per cycle while issuing and not stalled
        if (active && left > 0 && !af) begin
          e = elems.pop_front();
          if (e.inr) rdq.push_back(e.a);
          x.c = cyc;
          x.d = e.inr ? hash(e.a) : 32'h0;
          expq.push_back(x);
          left--;
          last = cyc;
        end
        if (ram_rd) begin
          if (rdq.size() == 0) begin
            chk(0, $sformatf("L%0d.spur_rd", L), ram_addr, 0);
          end else begin
            a = rdq.pop_front();
            chk(ram_addr == a, $sformatf("L%0d.rd_addr", L), ram_addr, a);
          end
        end
        if (push) begin
          if (expq.size() == 0) begin
            chk(0, $sformatf("L%0d.spur_push", L), dtf, 0);
          end else begin
            x = expq.pop_front();
            chk(cyc == x.c + L, $sformatf("L%0d.push_cyc", L),
                cyc, x.c + L);
            chk(dtf == x.d, $sformatf("L%0d.push_data", L), dtf, x.d);
          end
        end
        if (start && (!active || dm)) begin
          elems.delete();
          for (int tn = 0; tn < TN; tn++)
            for (int tm = 0; tm < TM; tm++)
              for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) begin
                  e.a = (bn + tn) * (M * K * K) + (bm + tm) * (K * K)
                        + i * K + j;
                  e.inr = (bn + tn < N) && (bm + tm < M);
                  elems.push_back(e);
                end
          left   = TN * TM * K * K;
          active = 1'b1;
        end else if (dm) begin
          active = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start(input int a, input int b);
    @(posedge clk);
    #1;
    start = 1'b1;
    bn    = a;
    bm    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while ((g_inst[0].active || g_inst[1].active) && n < LIM) begin
      @(posedge clk);
      #1;
      if (rnd) af = ($urandom_range(0, 3) == 0);
      n++;
    end
    af = 1'b0;
    chk(n < LIM, "idle_timeout", n, LIM);
    chk(g_inst[0].expq.size() == 0 && g_inst[0].rdq.size() == 0,
        "L2.pending", g_inst[0].expq.size(), 0);
    chk(g_inst[1].expq.size() == 0 && g_inst[1].rdq.size() == 0,
        "L4.pending", g_inst[1].expq.size(), 0);
    chk(!g_inst[0].busy && !g_inst[1].busy, "idle_busy",
        {g_inst[0].busy, g_inst[1].busy}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    pulse_start(0, 0);
    wait_idle(1'b0);

    pulse_start(3, 3);
    wait_idle(1'b0);

    pulse_start(1, 2);
    repeat (10) @(posedge clk);
    #1;
    af = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    af = 1'b0;
    wait_idle(1'b0);

    repeat (4) begin
      pulse_start($urandom_range(0, 4), $urandom_range(0, 4));
      wait_idle(1'b1);
    end

    @(posedge clk);
    #1;
    start = 1'b1;
    repeat (200) begin
      bn = $urandom_range(0, 4);
      bm = $urandom_range(0, 4);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle(1'b0);

    pulse_start(0, 1);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    pulse_start(2, 1);
    wait_idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
